// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with request/response handshake,
// configurable access latency and fault reporting for RV32I loads/stores.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic          w_legal;
  logic          w_misaligned;
  logic          w_fault;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wlanes;
  logic          w_do_access;

  assign req_ready   = (r_state == S_IDLE);
  assign w_idx       = r_addr[AW+1:2];
  assign w_word      = r_mem[w_idx];
  assign w_do_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

  // Decode legality, alignment, load extraction and store lane placement
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    w_load_data  = '0;
    w_wmask      = '0;
    w_wlanes     = '0;
    w_byte       = w_word[8*r_addr[1:0] +: 8];
    w_half       = r_addr[1] ? w_word[31:16] : w_word[15:0];

    case (r_funct3)
      3'b000: w_legal = 1'b1;
      3'b001: begin
        w_legal      = 1'b1;
        w_misaligned = r_addr[0];
      end
      3'b010: begin
        w_legal      = 1'b1;
        w_misaligned = |r_addr[1:0];
      end
      3'b100: w_legal = !r_write;
      3'b101: begin
        w_legal      = !r_write;
        w_misaligned = r_addr[0];
      end
      default: w_legal = 1'b0;
    endcase
    w_fault = !w_legal || w_misaligned;

    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = w_word;
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = '0;
    endcase

    case (r_funct3)
      3'b000: begin
        w_wmask  = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      3'b001: begin
        w_wmask  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      3'b010: begin
        w_wmask  = 4'b1111;
        w_wlanes = r_wdata;
      end
      default: begin
        w_wmask  = '0;
        w_wlanes = '0;
      end
    endcase
  end

  // Request sequencing and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 4'(LATENCY);
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= w_fault;
            resp_rdata <= (w_fault || r_write) ? '0 : w_load_data;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane RAM write; contents are never reset
  always_ff @(posedge clk) begin
    if (!reset && w_do_access && r_write && !w_fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  localparam int NI = 4;

  function automatic int unsigned lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 15;
      default: return 3;
    endcase
  endfunction

  logic              clk;
  logic              reset;
  logic [NI-1:0]     req_valid;
  logic [NI-1:0]     req_ready;
  logic [NI-1:0]     req_write;
  logic [2:0]        req_funct3 [NI];
  logic [31:0]       req_addr   [NI];
  logic [31:0]       req_wdata  [NI];
  logic [NI-1:0]     resp_valid;
  logic [31:0]       resp_rdata [NI];
  logic [NI-1:0]     resp_fault;

  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic        f;
    int unsigned due;
  } exp_t;

  exp_t sbq[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_lsu #(
      .DEPTH_WORDS(64),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_fault (resp_fault[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard whenever any DUT presents a response
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (resp_valid[i] !== 1'b0) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_resp: inst %0d got resp_valid with no pending request", i);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_inst", 32'(i), 32'(e.inst));
          check("resp_cycle", cyc, e.due);
          check("resp_rdata", resp_rdata[i], e.rd);
          check("resp_fault", {31'd0, resp_fault[i]}, {31'd0, e.f});
        end
      end
    end
  end

  task automatic drive_req(input int inst, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int unsigned acc);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (req_ready[inst] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[inst] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_wait: inst %0d req_ready never rose, got %b expected 1", inst, req_ready[inst]);
    end
    req_valid[inst]  = 1'b1;
    req_write[inst]  = wr;
    req_funct3[inst] = f3;
    req_addr[inst]   = addr;
    req_wdata[inst]  = wdata;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[inst]  = 1'b0;
    req_wdata[inst]  = $urandom;
    req_addr[inst]   = $urandom;
  endtask

  task automatic issue(input int inst, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_f, input bit pulse);
    int unsigned acc;
    int unsigned lat;
    exp_t e;
    lat = lat_of(inst);
    drive_req(inst, wr, f3, addr, wdata, acc);
    e.inst = inst;
    e.rd   = exp_rd;
    e.f    = exp_f;
    e.due  = acc + lat + 1;
    sbq.push_back(e);
    for (int unsigned k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      check("ready_low_busy", {31'd0, req_ready[inst]}, 32'd0);
      req_valid[inst] = pulse && (k <= lat);
    end
    @(negedge clk);
    req_valid[inst] = 1'b0;
    check("ready_high_after", {31'd0, req_ready[inst]}, 32'd1);
  endtask

  task automatic reset_midop(input int inst, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned acc;
    drive_req(inst, 1'b1, 3'b010, addr, wdata, acc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", {31'd0, req_ready[inst]}, 32'd1);
    check("rst_mid_valid", {31'd0, resp_valid[inst]}, 32'd0);
    repeat (lat_of(inst) + 4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    for (int i = 0; i < NI; i++) begin
      req_funct3[i] = '0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("reset_ready", {31'd0, req_ready[i]}, 32'd1);
      check("reset_valid", {31'd0, resp_valid[i]}, 32'd0);
      check("reset_rdata", resp_rdata[i], 32'd0);
      check("reset_fault", {31'd0, resp_fault[i]}, 32'd0);
    end

    // LATENCY=1: basic store/load
    issue(0, 1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 0, 0);
    issue(0, 0, 3'b010, 32'h10, 32'h0,         32'h8000_00F0, 0, 0);

    // Byte/half lanes
    issue(0, 1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0, 0);
    issue(0, 1, 3'b000, 32'h21, 32'h5566_77AA, 32'h0, 0, 0);
    issue(0, 1, 3'b001, 32'h22, 32'h1234_BEEF, 32'h0, 0, 0);
    issue(0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA44, 0, 0);
    issue(0, 0, 3'b000, 32'h21, 32'h0, 32'hFFFF_FFAA, 0, 0);
    issue(0, 0, 3'b100, 32'h21, 32'h0, 32'h0000_00AA, 0, 0);
    issue(0, 0, 3'b001, 32'h22, 32'h0, 32'hFFFF_BEEF, 0, 0);
    issue(0, 0, 3'b101, 32'h22, 32'h0, 32'h0000_BEEF, 0, 0);
    issue(0, 0, 3'b000, 32'h23, 32'h0, 32'hFFFF_FFBE, 0, 0);
    issue(0, 0, 3'b101, 32'h20, 32'h0, 32'h0000_AA44, 0, 0);
    issue(0, 0, 3'b000, 32'h20, 32'h0, 32'h0000_0044, 0, 0);

    // Faults
    issue(0, 1, 3'b010, 32'h30, 32'h5566_7788, 32'h0, 0, 0);
    issue(0, 1, 3'b010, 32'h32, 32'hDEAD_BEEF, 32'h0, 1, 0);
    issue(0, 0, 3'b010, 32'h30, 32'h0, 32'h5566_7788, 0, 0);
    issue(0, 0, 3'b001, 32'h31, 32'h0, 32'h0, 1, 0);
    issue(0, 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 0);
    issue(0, 1, 3'b100, 32'h20, 32'hFFFF_FFFF, 32'h0, 1, 0);
    issue(0, 1, 3'b001, 32'h21, 32'hFFFF_FFFF, 32'h0, 1, 0);
    issue(0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA44, 0, 0);

    // Address wrap-around modulo 256 bytes
    issue(0, 1, 3'b010, 32'h104, 32'hCAFE_BABE, 32'h0, 0, 0);
    issue(0, 0, 3'b010, 32'h004, 32'h0, 32'hCAFE_BABE, 0, 0);

    // LATENCY=0 and 15 with req_valid pulses while busy
    issue(1, 1, 3'b010, 32'h08, 32'hA5A5_A5A5, 32'h0, 0, 1);
    issue(1, 0, 3'b010, 32'h08, 32'h0, 32'hA5A5_A5A5, 0, 1);
    issue(2, 1, 3'b010, 32'h0C, 32'h0F0F_1234, 32'h0, 0, 1);
    issue(2, 0, 3'b010, 32'h0C, 32'h0, 32'h0F0F_1234, 0, 1);
    issue(2, 0, 3'b000, 32'h0C, 32'h0, 32'h0000_0034, 0, 0);

    // Reset during BUSY discards the pending store
    issue(3, 1, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0);
    reset_midop(3, 32'h40, 32'h1234_5678);
    issue(3, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
